// File: rtl/simple_processor_pkg.sv
// Shared widths for the simple processor front end.
package simple_processor_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 16;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC, imem request handshake, instruction FIFO, redirect handling.
// Optional wait-cycle counter built when FETCH_STALL_CNT_EN is defined.
module instr_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [ADDR_WIDTH-1:0] boot_addr_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  imem_ack_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           stall_cnt_o
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned EW    = AW + DW;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HOLD, ST_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    tgt_q, tgt_d;
  logic             req_q, req_d;
  logic             valid_q;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    target_c;
  logic             push_c, pop_c;
  logic [EW-1:0]    head_c;

  assign target_c = redirect_addr_i & ~AW'(1);
  assign push_c   = (state_q == ST_FETCH) && imem_ack_i && !redirect_i;
  assign pop_c    = valid_q && instr_ready_i && !redirect_i;
  assign cnt_d    = redirect_i ? '0 : (cnt_q + CNT_W'(push_c) - CNT_W'(pop_c));

  // Next state, PC and pending redirect target
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      ST_BOOT: begin
        pc_d    = redirect_i ? target_c : boot_addr_i;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_i) begin
          if (imem_ack_i) begin
            pc_d = target_c;
          end else begin
            tgt_d   = target_c;
            state_d = ST_DRAIN;
          end
        end else if (imem_ack_i) begin
          pc_d = pc_q + AW'(2);
          if (cnt_d == CNT_W'(FIFO_DEPTH)) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          pc_d    = target_c;
          state_d = ST_FETCH;
        end else if (cnt_d < CNT_W'(FIFO_DEPTH)) begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (redirect_i) tgt_d = target_c;
        // The outstanding request completes; its data is dropped
        if (imem_ack_i) begin
          pc_d    = redirect_i ? target_c : tgt_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_BOOT;
      pc_q    <= '0;
      tgt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      req_q   <= req_d;
    end
  end

  // Instruction FIFO; redirect flushes it on the same edge
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (redirect_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_c) begin
          mem_q[wr_ptr_q] <= {imem_rdata_i, pc_q};
          wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
    end
  end

  assign head_c        = mem_q[rd_ptr_q];
  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = head_c[AW +: DW];
  assign instr_pc_o    = head_c[AW-1:0];

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Counts cycles a request waits for its ack, saturating
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      stall_cnt_q <= '0;
    end else if (req_q && !imem_ack_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch, hold, redirect, wrap, stall and reset scenarios.
module tb_instr_fetch_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic [AW-1:0] boot_addr_i = '0;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_addr_i = '0;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic [DW-1:0] imem_rdata_i;
  logic          imem_ack_i;
  logic          instr_valid_o;
  logic [DW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;
  logic          instr_ready_i = 1'b0;
  logic [31:0]   stall_cnt_o;

  instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .boot_addr_i(boot_addr_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_ack_i(imem_ack_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int ack_seen = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] exp_pc_q[$];
  logic [AW-1:0] pc_tmp;
  logic ack_en = 1'b0;
  logic force_ack = 1'b0;
  int ack_delay = 0;
  int wait_cnt = 0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return DW'(a) ^ DW'(16'h5A5A);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endfunction

  // Memory responder: acks after ack_delay wait cycles
  initial begin
    imem_ack_i = 1'b0;
    imem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      if (!arst_ni) wait_cnt = 0;
      if (force_ack) begin
        imem_ack_i = 1'b1;
        imem_rdata_i = mem_fn(imem_addr_o);
      end else if (ack_en && imem_req_o && wait_cnt >= ack_delay) begin
        imem_ack_i = 1'b1;
        imem_rdata_i = mem_fn(imem_addr_o);
        wait_cnt = 0;
      end else begin
        imem_ack_i = 1'b0;
        imem_rdata_i = '0;
        if (ack_en && imem_req_o) wait_cnt++;
        else wait_cnt = 0;
      end
    end
  end

  // Monitor: compares completed requests and consumed instructions against the scoreboard
  always @(negedge clk_i) begin
    if (arst_ni && imem_req_o && imem_ack_i) begin
      ack_seen++;
      if (exp_addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL imem_addr_unexpected: got %h expected none", imem_addr_o);
      end else begin
        check("imem_addr", 32'(imem_addr_o), 32'(exp_addr_q.pop_front()));
      end
    end
    if (arst_ni && instr_valid_o && instr_ready_i && !redirect_i) begin
      if (exp_pc_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL instr_unexpected: got pc %h expected none", instr_pc_o);
      end else begin
        pc_tmp = exp_pc_q.pop_front();
        check("instr_pc", 32'(instr_pc_o), 32'(pc_tmp));
        check("instr_data", 32'(instr_o), 32'(mem_fn(pc_tmp)));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_acks(input int n);
    int target;
    int t;
    target = ack_seen + n;
    t = 0;
    while (ack_seen < target && t < 200) begin
      tick();
      t++;
    end
    if (ack_seen < target) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: got %0d acks expected %0d", ack_seen, target);
    end
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while ((exp_addr_q.size() != 0 || exp_pc_q.size() != 0) && t < 100) begin
      tick();
      t++;
    end
    check("sb_addr_left", 32'(exp_addr_q.size()), 32'd0);
    check("sb_instr_left", 32'(exp_pc_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_pc_q.delete();
  endtask

  // Asserts reset mid-cycle, checks outputs without a clock edge, releases into BOOT
  task automatic apply_reset(input logic [AW-1:0] boot);
    @(negedge clk_i);
    #1;
    ack_en = 1'b0;
    force_ack = 1'b0;
    redirect_i = 1'b0;
    instr_ready_i = 1'b0;
    ack_delay = 0;
    arst_ni = 1'b0;
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_addr", 32'(imem_addr_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", 32'(instr_o), 32'd0);
    check("rst_pc", 32'(instr_pc_o), 32'd0);
    check("rst_stall", stall_cnt_o, 32'd0);
    boot_addr_i = boot;
    repeat (2) @(posedge clk_i);
    #1;
    arst_ni = 1'b1;
  endtask

  initial begin
    // Sequential fetch with back-to-back acks
    apply_reset(16'h0100);
    instr_ready_i = 1'b1;
    ack_en = 1'b1;
    exp_addr_q = '{16'h0100, 16'h0102, 16'h0104};
    exp_pc_q = '{16'h0100, 16'h0102, 16'h0104};
    check("boot_req_low", 32'(imem_req_o), 32'd0);
    tick();
    @(negedge clk_i);
    check("first_req", 32'(imem_req_o), 32'd1);
    check("first_valid_low", 32'(instr_valid_o), 32'd0);
    tick();
    @(negedge clk_i);
    check("latency_valid", 32'(instr_valid_o), 32'd1);
    check("latency_pc", 32'(instr_pc_o), 32'h0100);
    tick();
    tick();
    ack_en = 1'b0;
    wait_empty();

    // FIFO fills, HOLD, resume after one pop
    apply_reset(16'h0100);
    ack_en = 1'b1;
    exp_addr_q = '{16'h0100, 16'h0102, 16'h0104, 16'h0106, 16'h0108};
    exp_pc_q = '{16'h0100, 16'h0102, 16'h0104, 16'h0106, 16'h0108};
    wait_acks(4);
    @(negedge clk_i);
    check("hold_req", 32'(imem_req_o), 32'd0);
    check("hold_valid", 32'(instr_valid_o), 32'd1);
    check("hold_head", 32'(instr_pc_o), 32'h0100);
    tick();
    @(negedge clk_i);
    check("hold_req2", 32'(imem_req_o), 32'd0);
    tick();
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    @(negedge clk_i);
    check("resume_req", 32'(imem_req_o), 32'd1);
    check("resume_addr", 32'(imem_addr_o), 32'h0108);
    tick();
    ack_en = 1'b0;
    instr_ready_i = 1'b1;
    wait_empty();

    // Redirect while a slow ack is pending
    apply_reset(16'h0100);
    instr_ready_i = 1'b1;
    ack_delay = 3;
    ack_en = 1'b1;
    exp_addr_q = '{16'h0100, 16'h0200};
    exp_pc_q = '{16'h0200};
    tick();
    tick();
    redirect_i = 1'b1;
    redirect_addr_i = 16'h0201;
    tick();
    redirect_i = 1'b0;
    @(negedge clk_i);
    check("drain_req", 32'(imem_req_o), 32'd1);
    check("drain_addr", 32'(imem_addr_o), 32'h0100);
    tick();
    @(negedge clk_i);
    check("drain_ack_addr", 32'(imem_addr_o), 32'h0100);
    tick();
    @(negedge clk_i);
    check("redir_addr", 32'(imem_addr_o), 32'h0200);
    check("redir_req", 32'(imem_req_o), 32'd1);
    check("redir_empty", 32'(instr_valid_o), 32'd0);
    wait_acks(1);
    ack_en = 1'b0;
    wait_empty();

    // PC wraps at the top of the address space
    apply_reset(16'hFFFE);
    instr_ready_i = 1'b1;
    ack_en = 1'b1;
    exp_addr_q = '{16'hFFFE, 16'h0000};
    exp_pc_q = '{16'hFFFE, 16'h0000};
    tick();
    tick();
    @(negedge clk_i);
    check("wrap_addr", 32'(imem_addr_o), 32'h0000);
    tick();
    ack_en = 1'b0;
    wait_empty();

    // Wait-cycle counter
    apply_reset(16'h0300);
    instr_ready_i = 1'b1;
    ack_delay = 5;
    ack_en = 1'b1;
    exp_addr_q = '{16'h0300};
    exp_pc_q = '{16'h0300};
    wait_acks(1);
    ack_en = 1'b0;
    @(negedge clk_i);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt", stall_cnt_o, 32'd5);
`else
    check("stall_cnt", stall_cnt_o, 32'd0);
`endif
    wait_empty();

    // Reset mid-request, late ack and redirect in BOOT
    apply_reset(16'h0100);
    force_ack = 1'b1;
    redirect_i = 1'b1;
    redirect_addr_i = 16'h0401;
    tick();
    force_ack = 1'b0;
    redirect_i = 1'b0;
    @(negedge clk_i);
    check("boot_redir_addr", 32'(imem_addr_o), 32'h0400);
    check("boot_redir_req", 32'(imem_req_o), 32'd1);
    check("late_ack_ignored", 32'(instr_valid_o), 32'd0);
    tick();
    @(negedge clk_i);
    check("late_ack_ignored2", 32'(instr_valid_o), 32'd0);

    // Redirect coinciding with an ack in FETCH
    apply_reset(16'h0100);
    ack_en = 1'b1;
    exp_addr_q = '{16'h0100, 16'h0102, 16'h0500};
    exp_pc_q = '{16'h0500};
    tick();
    tick();
    redirect_i = 1'b1;
    redirect_addr_i = 16'h0500;
    tick();
    redirect_i = 1'b0;
    @(negedge clk_i);
    check("redir_ack_addr", 32'(imem_addr_o), 32'h0500);
    check("redir_ack_flush", 32'(instr_valid_o), 32'd0);
    tick();
    ack_en = 1'b0;
    instr_ready_i = 1'b1;
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
